// File: rtl/mul_err_accum.sv
// mul_err_accum: accumulates error statistics of an approximate multiplier
// against the exact product over a campaign of n_samples operand pairs.
module mul_err_accum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2*WIDTH:0] approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic             sum_sat,
  output logic [2*WIDTH:0] max_ed,
  output logic [WIDTH-1:0] max_in1,
  output logic [WIDTH-1:0] max_in2
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned DW = 2 * WIDTH + 2;
  // Accumulator add is one bit wider than the larger operand to expose overflow.
  localparam int unsigned AW = ((SUM_W > EW) ? SUM_W : EW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             busy_q, done_q;
  logic             accept;

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_in1_q, s1_in2_q;
  logic [EW-1:0]    s1_approx_q, s1_exact_q;
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_in1_q, s2_in2_q;
  logic [EW-1:0]    s2_ed_q;

  logic [CNT_W-1:0] sample_cnt_q, err_cnt_q;
  logic [SUM_W-1:0] sum_q;
  logic             sat_q;
  logic [EW-1:0]    max_ed_q;
  logic [WIDTH-1:0] max_in1_q, max_in2_q;

  logic [PW-1:0]    prod;
  logic [DW-1:0]    diff;
  logic [EW-1:0]    ed;
  logic [AW-1:0]    sum_ext;
  logic             sum_ovf;

  // Accept only while the campaign still needs samples; start always wins.
  assign in_ready = (state_q == S_RUN) && (acc_cnt_q != n_q) && !start;
  assign accept   = in_valid && in_ready;

  // Next-state and campaign bookkeeping
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    acc_cnt_d = acc_cnt_q;
    if (start) begin
      state_d   = S_RUN;
      n_d       = n_samples;
      acc_cnt_d = '0;
    end else begin
      if (accept) acc_cnt_d = acc_cnt_q + CNT_W'(1);
      case (state_q)
        S_RUN:   if (acc_cnt_d == n_q) state_d = S_DRAIN;
        S_DRAIN: if (!s1_v_q && !s2_v_q) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  // State register with registered status decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      acc_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      acc_cnt_q <= acc_cnt_d;
      busy_q    <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
    end
  end

  // Exact product, signed difference and its magnitude
  assign prod    = PW'(in1) * PW'(in2);
  assign diff    = DW'(s1_exact_q) - DW'(s1_approx_q);
  assign ed      = diff[DW-1] ? EW'(-diff) : EW'(diff);
  assign sum_ext = AW'(sum_q) + AW'(s2_ed_q);
  assign sum_ovf = |(sum_ext >> SUM_W);

  // Two-stage pipeline; start flushes anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_in1_q    <= '0;
      s1_in2_q    <= '0;
      s1_approx_q <= '0;
      s1_exact_q  <= '0;
      s2_v_q      <= 1'b0;
      s2_in1_q    <= '0;
      s2_in2_q    <= '0;
      s2_ed_q     <= '0;
    end else if (start) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_in1_q    <= in1;
        s1_in2_q    <= in2;
        s1_approx_q <= approx;
        s1_exact_q  <= EW'(prod);
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_in1_q <= s1_in1_q;
        s2_in2_q <= s1_in2_q;
        s2_ed_q  <= ed;
      end
    end
  end

  // Statistics update from stage 2; start clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_q        <= '0;
      sat_q        <= 1'b0;
      max_ed_q     <= '0;
      max_in1_q    <= '0;
      max_in2_q    <= '0;
    end else if (start) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_q        <= '0;
      sat_q        <= 1'b0;
      max_ed_q     <= '0;
      max_in1_q    <= '0;
      max_in2_q    <= '0;
    end else if (s2_v_q) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (s2_ed_q != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (sum_ovf) begin
        sum_q <= '1;
        sat_q <= 1'b1;
      end else begin
        sum_q <= sum_ext[SUM_W-1:0];
      end
      if (s2_ed_q > max_ed_q) begin
        max_ed_q  <= s2_ed_q;
        max_in1_q <= s2_in1_q;
        max_in2_q <= s2_in2_q;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_q;
  assign sum_sat    = sat_q;
  assign max_ed     = max_ed_q;
  assign max_in1    = max_in1_q;
  assign max_in2    = max_in2_q;

endmodule

// File: tb/tb_mul_err_accum.sv
// Testbench for mul_err_accum: scenario tasks checked against a
// sample-list statistics model.
module tb_mul_err_accum;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 48;
  localparam int unsigned EW = 2 * W + 1;
  localparam int unsigned ST = 2 * CW + SW + 1 + EW + 2 * W;
  localparam longint SUM_MAX = (longint'(1) << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] n_samples;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1, in2;
  logic [EW-1:0] approx;
  logic          busy, done, sum_sat;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [SW-1:0] sum_ed;
  logic [EW-1:0] max_ed;
  logic [W-1:0]  max_in1, max_in2;

  logic          sat_in_ready, sat_busy, sat_done, sat_sat;
  logic [CW-1:0] sat_sample_cnt, sat_err_cnt;
  logic [3:0]    sat_sum;
  logic [EW-1:0] sat_max_ed;
  logic [W-1:0]  sat_max_in1, sat_max_in2;

  logic [ST-1:0] got_s;
  assign got_s = {sample_cnt, err_cnt, sum_ed, sum_sat, max_ed, max_in1, max_in2};

  always #5 clk = ~clk;

  mul_err_accum #(.WIDTH(W), .CNT_W(CW), .SUM_W(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx(approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_ed(sum_ed), .sum_sat(sum_sat), .max_ed(max_ed),
    .max_in1(max_in1), .max_in2(max_in2)
  );

  mul_err_accum #(.WIDTH(W), .CNT_W(CW), .SUM_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in1(in1), .in2(in2),
    .approx(approx), .busy(sat_busy), .done(sat_done),
    .sample_cnt(sat_sample_cnt), .err_cnt(sat_err_cnt), .sum_ed(sat_sum),
    .sum_sat(sat_sat), .max_ed(sat_max_ed), .max_in1(sat_max_in1),
    .max_in2(sat_max_in2)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: campaign state plus statistics of accepted samples
  bit          m_run;
  int unsigned m_n, m_acc;
  longint      m_cnt, m_err, m_sum, m_max;
  bit          m_sat;
  int unsigned m_max1, m_max2;

  task automatic model_clear_stats();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sat = 0; m_max1 = 0; m_max2 = 0;
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 0; m_acc = 0;
    model_clear_stats();
  endtask

  task automatic model_start(input int unsigned n);
    m_run = 1; m_n = n; m_acc = 0;
    model_clear_stats();
  endtask

  task automatic model_add(input int unsigned a, input int unsigned b, input int unsigned ap);
    longint ex, e;
    ex = longint'(a) * longint'(b);
    e  = (ex > longint'(ap)) ? ex - longint'(ap) : longint'(ap) - ex;
    m_cnt++;
    if (e != 0) m_err++;
    if (m_sum + e > SUM_MAX) begin m_sum = SUM_MAX; m_sat = 1; end
    else m_sum = m_sum + e;
    if (e > m_max) begin m_max = e; m_max1 = a; m_max2 = b; end
  endtask

  function automatic logic [ST-1:0] exp_stats();
    return {CW'(m_cnt), CW'(m_err), SW'(m_sum), m_sat, EW'(m_max), W'(m_max1), W'(m_max2)};
  endfunction

  task automatic put(input bit v, input int unsigned a, input int unsigned b, input int unsigned ap);
    start = 0; in_valid = v; in1 = W'(a); in2 = W'(b); approx = EW'(ap);
  endtask

  // One clock: check in_ready against the model, advance model, clock
  task automatic step();
    bit exp_rdy;
    #1;
    exp_rdy = m_run && (m_acc != m_n) && !start;
    n_total++;
    if (in_ready !== exp_rdy)
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
    else n_pass++;
    if (start) model_start(n_samples);
    else if (in_valid && exp_rdy) begin
      model_add(in1, in2, approx);
      m_acc++;
      if (m_acc == m_n) m_run = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int unsigned n);
    start = 1; n_samples = CW'(n); in_valid = 0;
    step();
    start = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    put(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    #12;
    n_total++;
    if ({busy, done, in_ready, got_s} !== '0)
      $display("FAIL reset.initial got busy=%b done=%b rdy=%b stats=%h want all 0", busy, done, in_ready, got_s);
    else n_pass++;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    pulse_start(5);
    put(1, 10, 10, 96);    step();
    put(1, 255, 255, 65000); step();
    put(1, 2, 3, 7);       step();
    put(0, 0, 0, 0);       step(); step();
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL reset.pre_stats got %h want %h", got_s, exp_stats());
    else n_pass++;
    put(1, 4, 4, 3);
    #2 rst_n = 0;
    #1;
    n_total++;
    if ({busy, done, in_ready, got_s} !== '0)
      $display("FAIL reset.async got busy=%b done=%b rdy=%b stats=%h want all 0", busy, done, in_ready, got_s);
    else n_pass++;
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    put(1, 4, 4, 3);
    step();
    wait_done(ok);
    n_total++;
    if (ok || busy !== 1'b0) $display("FAIL reset.idle got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_exact();
    int unsigned ea[4] = '{3, 0, 255, 16};
    int unsigned eb[4] = '{5, 255, 255, 16};
    int unsigned ep[4] = '{15, 0, 65025, 256};
    pulse_start(4);
    for (int i = 0; i < 4; i++) begin put(1, ea[i], eb[i], ep[i]); step(); end
    put(0, 0, 0, 0);
    n_total++;
    if ({busy, done} !== 2'b10) $display("FAIL exact.drain got busy,done=%b want 10", {busy, done});
    else n_pass++;
    step();
    n_total++;
    if (done !== 1'b0) $display("FAIL exact.done_e1 got %b want 0", done);
    else n_pass++;
    step();
    n_total++;
    if ({done, got_s} !== {1'b0, exp_stats()})
      $display("FAIL exact.stats_e2 got %b/%h want 0/%h", done, got_s, exp_stats());
    else n_pass++;
    step();
    n_total++;
    if ({busy, done} !== 2'b01) $display("FAIL exact.done_e3 got busy,done=%b want 01", {busy, done});
    else n_pass++;
    n_total++;
    if ({sample_cnt, err_cnt, sum_ed, max_ed} !== {CW'(4), CW'(0), SW'(0), EW'(0)})
      $display("FAIL exact.values got cnt=%0d err=%0d sum=%0d max=%0d want 4 0 0 0", sample_cnt, err_cnt, sum_ed, max_ed);
    else n_pass++;
  endtask

  task automatic test_error();
    bit ok;
    pulse_start(3);
    put(1, 10, 10, 96);      step();
    put(1, 255, 255, 65000); step();
    put(1, 2, 3, 7);         step();
    wait_done(ok);
    n_total++;
    if (!ok) $display("FAIL error.timeout done=%b want 1", done);
    else n_pass++;
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL error.stats got %h want %h", got_s, exp_stats());
    else n_pass++;
    n_total++;
    if ({err_cnt, sum_ed, max_ed, max_in1, max_in2} !== {CW'(3), SW'(30), EW'(25), W'(255), W'(255)})
      $display("FAIL error.values got err=%0d sum=%0d max=%0d in=%0d,%0d want 3 30 25 255,255",
               err_cnt, sum_ed, max_ed, max_in1, max_in2);
    else n_pass++;
  endtask

  task automatic test_max_first();
    bit ok;
    pulse_start(3);
    put(1, 10, 10, 96); step();
    put(1, 20, 5, 104); step();
    put(1, 1, 1, 1);    step();
    wait_done(ok);
    n_total++;
    if (!ok || got_s !== exp_stats()) $display("FAIL maxfirst.stats got %h want %h", got_s, exp_stats());
    else n_pass++;
    n_total++;
    if ({max_ed, max_in1, max_in2} !== {EW'(4), W'(10), W'(10)})
      $display("FAIL maxfirst.operands got %0d %0d,%0d want 4 10,10", max_ed, max_in1, max_in2);
    else n_pass++;
  endtask

  task automatic test_oversupply();
    bit ok;
    pulse_start(2);
    for (int i = 0; i < 5; i++) begin
      put(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
      step();
    end
    wait_done(ok);
    n_total++;
    if (!ok || sample_cnt !== CW'(2)) $display("FAIL oversupply.count got %0d done=%b want 2", sample_cnt, done);
    else n_pass++;
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL oversupply.stats got %h want %h", got_s, exp_stats());
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    pulse_start(10);
    put(1, 10, 10, 96); step();
    put(1, 20, 20, 1);  step();
    put(1, 30, 30, 5);  step();
    put(1, 9, 9, 0);
    start = 1; n_samples = CW'(1);
    step();
    start = 0;
    put(0, 0, 0, 0);
    n_total++;
    if ({busy, sample_cnt} !== {1'b1, CW'(0)}) $display("FAIL abort.cleared got busy=%b cnt=%0d want 1 0", busy, sample_cnt);
    else n_pass++;
    step(); step(); step();
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL abort.inflight got %h want %h", got_s, exp_stats());
    else n_pass++;
    put(1, 7, 7, 50); step();
    wait_done(ok);
    n_total++;
    if (!ok || sample_cnt !== CW'(1)) $display("FAIL abort.new got cnt=%0d done=%b want 1 1", sample_cnt, done);
    else n_pass++;
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL abort.stats got %h want %h", got_s, exp_stats());
    else n_pass++;
  endtask

  task automatic test_saturation();
    bit ok;
    pulse_start(2);
    put(1, 0, 0, 10); step();
    put(1, 0, 0, 9);  step();
    put(0, 0, 0, 0);  step();
    n_total++;
    if ({sat_sat, sat_sum} !== {1'b0, 4'd10}) $display("FAIL sat.first got sat=%b sum=%0d want 0 10", sat_sat, sat_sum);
    else n_pass++;
    step();
    n_total++;
    if ({sat_sat, sat_sum} !== {1'b1, 4'd15}) $display("FAIL sat.second got sat=%b sum=%0d want 1 15", sat_sat, sat_sum);
    else n_pass++;
    wait_done(ok);
    n_total++;
    if (!ok || {sat_done, sat_sample_cnt, sat_err_cnt} !== {1'b1, CW'(2), CW'(2)})
      $display("FAIL sat.final got done=%b cnt=%0d err=%0d want 1 2 2", sat_done, sat_sample_cnt, sat_err_cnt);
    else n_pass++;
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL sat.wide got %h want %h", got_s, exp_stats());
    else n_pass++;
  endtask

  task automatic test_zero();
    pulse_start(0);
    n_total++;
    if ({busy, done} !== 2'b10) $display("FAIL zero.run got busy,done=%b want 10", {busy, done});
    else n_pass++;
    put(1, 5, 5, 20); step();
    n_total++;
    if ({busy, done} !== 2'b10) $display("FAIL zero.drain got busy,done=%b want 10", {busy, done});
    else n_pass++;
    step();
    n_total++;
    if ({busy, done, got_s} !== {2'b01, ST'(0)}) $display("FAIL zero.done got busy,done=%b stats=%h want 01 0", {busy, done}, got_s);
    else n_pass++;
  endtask

  task automatic test_random(input int unsigned n);
    bit ok;
    int unsigned a, b, ex, d, ap;
    pulse_start(n);
    for (int i = 0; i < 400 && m_acc != m_n; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); ex = a * b;
      d = $urandom_range(1, 300);
      case ($urandom_range(0, 3))
        0: ap = ex;
        1: ap = ex + d;
        2: ap = (ex >= d) ? ex - d : 0;
        default: ap = $urandom_range(0, 131071);
      endcase
      put($urandom_range(0, 3) != 0, a, b, ap);
      step();
    end
    wait_done(ok);
    n_total++;
    if (!ok) $display("FAIL random.timeout n=%0d done=%b want 1", n, done);
    else n_pass++;
    n_total++;
    if (got_s !== exp_stats()) $display("FAIL random.stats n=%0d got %h want %h", n, got_s, exp_stats());
    else n_pass++;
  endtask

  initial begin
    rst_n = 0; start = 0; n_samples = '0; in_valid = 0; in1 = '0; in2 = '0; approx = '0;
    model_reset();
    test_reset();
    test_exact();
    test_error();
    test_max_first();
    test_oversupply();
    test_abort();
    test_saturation();
    test_zero();
    test_random(24);
    test_random(40);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
